// File: rtl/bnn_host_ctrl.sv
// Host-side sequencer for a BNN accelerator: streams one image into activation
// memory, kicks inference, reads back the class scores and reports the argmax.
module bnn_host_ctrl #(
  parameter int unsigned NUM_PIX  = 784,
  parameter int unsigned NUM_OUT  = 10,
  parameter int unsigned OUT_BASE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        pix_ready,
  output logic        bnn_enb_wr,
  output logic [7:0]  bnn_wr_data,
  output logic [10:0] bnn_addr_wr,
  output logic [10:0] bnn_addr_rd,
  output logic        bnn_start,
  input  logic        bnn_done,
  input  logic [7:0]  bnn_act_out,
  output logic        class_valid,
  input  logic        class_ready,
  output logic [3:0]  class_id,
  output logic [7:0]  class_score,
  output logic        busy
);

  typedef enum logic [2:0] {LOAD, START, WAIT, READ, RESULT} state_t;

  state_t      state, state_nx;
  logic [10:0] pix_cnt;
  logic [10:0] rd_cnt;
  logic [1:0]  st_cnt;
  logic [7:0]  best_score;
  logic [3:0]  best_id;
  logic        accept, last_pix, take_new;
  logic [3:0]  cur_idx;

  assign accept   = pix_valid && pix_ready;
  assign last_pix = (pix_cnt == 11'(NUM_PIX - 1));
  // Score arriving now belongs to the address issued one cycle earlier.
  assign take_new = (rd_cnt == 11'd1) || (bnn_act_out > best_score);
  assign cur_idx  = 4'(rd_cnt - 11'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    pix_ready   = 1'b0;
    bnn_start   = 1'b0;
    bnn_addr_rd = '0;
    class_valid = 1'b0;
    busy        = 1'b1;
    unique case (state)
      LOAD: begin
        pix_ready = rst_n;
        busy      = (pix_cnt != '0);
        if (pix_valid && last_pix) state_nx = START;
      end
      START: begin
        // First START cycle carries the final write; the pulse follows it.
        bnn_start = (st_cnt != 2'd0);
        if (st_cnt == 2'd2) state_nx = WAIT;
      end
      WAIT: begin
        if (bnn_done) state_nx = READ;
      end
      READ: begin
        if (rd_cnt < 11'(NUM_OUT)) bnn_addr_rd = 11'(OUT_BASE) + rd_cnt;
        if (rd_cnt == 11'(NUM_OUT)) state_nx = RESULT;
      end
      RESULT: begin
        class_valid = 1'b1;
        if (class_ready) state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt     <= '0;
      bnn_enb_wr  <= 1'b0;
      bnn_addr_wr <= '0;
      bnn_wr_data <= '0;
      st_cnt      <= '0;
      rd_cnt      <= '0;
      best_score  <= '0;
      best_id     <= '0;
      class_id    <= '0;
      class_score <= '0;
    end else begin
      bnn_enb_wr <= accept;
      if (accept) begin
        bnn_addr_wr <= pix_cnt;
        bnn_wr_data <= pix_data;
        pix_cnt     <= last_pix ? '0 : pix_cnt + 11'd1;
      end
      st_cnt <= (state == START) ? st_cnt + 2'd1 : '0;
      rd_cnt <= (state == READ) ? rd_cnt + 11'd1 : '0;
      if (state == READ && rd_cnt != '0 && take_new) begin
        best_score <= bnn_act_out;
        best_id    <= cur_idx;
      end
      // Last score is folded in directly so the result is ready on entering RESULT.
      if (state == READ && rd_cnt == 11'(NUM_OUT)) begin
        class_id    <= take_new ? cur_idx : best_id;
        class_score <= take_new ? bnn_act_out : best_score;
      end
    end
  end

endmodule

// File: tb/tb_bnn_host_ctrl.sv
// Scoreboard bench for bnn_host_ctrl: pixel writes and class results are
// queued when stimulus is driven and checked when the DUT produces them.
module tb_bnn_host_ctrl;

  localparam int NUM_PIX  = 784;
  localparam int NUM_OUT  = 10;
  localparam int OUT_BASE = 16;

  logic        clk = 1'b0;
  logic        rst_n, pix_valid, pix_ready, bnn_enb_wr, bnn_start, bnn_done;
  logic [7:0]  pix_data, bnn_wr_data, bnn_act_out, class_score;
  logic [10:0] bnn_addr_wr, bnn_addr_rd;
  logic        class_valid, class_ready, busy;
  logic [3:0]  class_id;

  bnn_host_ctrl #(.NUM_PIX(NUM_PIX), .NUM_OUT(NUM_OUT), .OUT_BASE(OUT_BASE)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .bnn_enb_wr(bnn_enb_wr), .bnn_wr_data(bnn_wr_data),
    .bnn_addr_wr(bnn_addr_wr), .bnn_addr_rd(bnn_addr_rd), .bnn_start(bnn_start),
    .bnn_done(bnn_done), .bnn_act_out(bnn_act_out), .class_valid(class_valid),
    .class_ready(class_ready), .class_id(class_id), .class_score(class_score),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [10:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic [3:0] id; logic [7:0] sc; } res_t;
  wr_t  wq[$];
  res_t cq[$];

  logic [7:0] scores[NUM_OUT];
  int total = 0, bad = 0, cyc = 0;
  int wr_cnt = 0, w_base = 0, last_wr = 0;
  int first_start = 0, start_len = 0, first_rd = 0, rd_idx = 0;
  bit prev_st = 0, prev_rd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Activation memory: one-cycle read latency, out-of-range reads give 0xFF.
  always @(posedge clk) begin
    int idx;
    idx = int'(bnn_addr_rd) - OUT_BASE;
    bnn_act_out <= (idx >= 0 && idx < NUM_OUT) ? scores[idx] : 8'hFF;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({pix_ready, bnn_enb_wr, bnn_wr_data, bnn_addr_wr, bnn_addr_rd,
                bnn_start, class_valid, class_id, class_score, busy});
  endfunction

  task automatic mon();
    wr_t e;
    if (!rst_n) begin
      prev_st = 0;
      prev_rd = 0;
    end else begin
      if (bnn_enb_wr) begin
        chk("wr_pending", 64'(wq.size() != 0), 64'd1);
        if (wq.size() != 0) begin
          e = wq.pop_front();
          chk("wr_addr", 64'(bnn_addr_wr), 64'(e.a));
          chk("wr_data", 64'(bnn_wr_data), 64'(e.d));
        end
        wr_cnt++;
        last_wr = cyc;
      end
      if (bnn_start) begin
        if (!prev_st) begin first_start = cyc; start_len = 0; end
        start_len++;
      end
      prev_st = bnn_start;
      if (bnn_addr_rd != '0) begin
        if (!prev_rd) begin first_rd = cyc; rd_idx = 0; end
        chk("rd_addr", 64'(bnn_addr_rd), 64'(OUT_BASE + rd_idx));
        rd_idx++;
      end
      prev_rd = (bnn_addr_rd != '0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
  endtask

  task automatic push_result();
    res_t r;
    r.id = '0;
    r.sc = scores[0];
    for (int i = 1; i < NUM_OUT; i++)
      if (scores[i] > r.sc) begin r.id = 4'(i); r.sc = scores[i]; end
    cq.push_back(r);
  endtask

  task automatic load(input int stop_at, input bit gaps);
    int n = 0, g = 0;
    w_base = wr_cnt;
    while (n < stop_at && g < 5000) begin
      tick();
      g++;
      pix_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      pix_data  = pix_valid ? 8'(n) : 8'hA5;
      if (pix_valid && pix_ready) begin
        wq.push_back('{a: 11'(n), d: 8'(n)});
        n++;
      end
    end
    tick();
    pix_valid = 1'b0;
    chk("load_count", 64'(n), 64'(stop_at));
  endtask

  task automatic wait_start();
    int g = 0;
    while (!bnn_start && g < 50) begin tick(); g++; end
    chk("start_seen", 64'(bnn_start), 64'd1);
    chk("ready_in_start", 64'(pix_ready), 64'd0);
    chk("busy_in_start", 64'(busy), 64'd1);
  endtask

  task automatic finish_image(input bit done_hold, input bit ready_hold, input bit ready_always);
    int g = 0, rise;
    res_t want;
    bit stable;
    wait_start();
    if (done_hold) bnn_done = 1'b0;
    repeat (done_hold ? 30 : 5) tick();
    chk("start_len", 64'(start_len), 64'd2);
    chk("start_after_wr", 64'(first_start), 64'(last_wr + 1));
    chk("wr_count", 64'(wr_cnt - w_base), 64'(NUM_PIX));
    chk("wq_empty", 64'(wq.size()), 64'd0);
    bnn_done = 1'b1;
    rise = cyc;
    while (!class_valid && g < 50) begin tick(); g++; end
    chk("result_seen", 64'(class_valid), 64'd1);
    bnn_done = 1'b0;
    chk("rd_first", 64'(first_rd), 64'(rise + 1));
    chk("rd_count", 64'(rd_idx), 64'(NUM_OUT));
    chk("cq_nonempty", 64'(cq.size() != 0), 64'd1);
    if (cq.size() != 0) begin
      want = cq.pop_front();
      chk("class_id", 64'(class_id), 64'(want.id));
      chk("class_score", 64'(class_score), 64'(want.sc));
      if (ready_hold) begin
        stable = 1;
        repeat (20) begin
          tick();
          if (!class_valid || class_id !== want.id || class_score !== want.sc) stable = 0;
        end
        chk("result_hold", 64'(stable), 64'd1);
      end
    end
    class_ready = 1'b1;
    tick();
    class_ready = ready_always;
    chk("post_valid", 64'(class_valid), 64'd0);
    chk("post_ready", 64'(pix_ready), 64'd1);
    chk("post_busy", 64'(busy), 64'd0);
  endtask

  task automatic reset_pulse(input string tag);
    tick();
    rst_n = 1'b0;
    #1;
    chk(tag, outs(), 64'd0);
    bnn_done = 1'b0;
    wq.delete();
    cq.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 64'(pix_ready), 64'd1);
    chk("rel_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int g;
    rst_n = 1'b0; pix_valid = 1'b0; pix_data = '0; bnn_done = 1'b0; class_ready = 1'b0;
    for (int i = 0; i < NUM_OUT; i++) scores[i] = '0;
    repeat (3) tick();
    chk("reset_outs", outs(), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 64'(pix_ready), 64'd1);
    chk("rel_busy", 64'(busy), 64'd0);

    // Back-to-back stream, higher score later wins.
    scores = '{8'd3, 8'd200, 8'd7, 8'd200, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255};
    cq.push_back('{id: 4'd9, sc: 8'd255});
    load(NUM_PIX, 1'b0);
    finish_image(1'b0, 1'b0, 1'b0);

    // Gapped stream, done held high across START, tie keeps lowest index.
    scores = '{8'd5, 8'd9, 8'd9, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    cq.push_back('{id: 4'd1, sc: 8'd9});
    bnn_done = 1'b1;
    load(NUM_PIX, 1'b1);
    finish_image(1'b1, 1'b1, 1'b0);

    // Random tie-prone scores, class_ready high throughout.
    for (int i = 0; i < NUM_OUT; i++) scores[i] = 8'($urandom_range(0, 4) * 60);
    push_result();
    class_ready = 1'b1;
    load(NUM_PIX, 1'b1);
    finish_image(1'b0, 1'b0, 1'b1);
    class_ready = 1'b0;

    // Reset after 400 pixels.
    load(400, 1'b0);
    chk("busy_mid_load", 64'(busy), 64'd1);
    reset_pulse("reset_load_outs");

    // Reset during READ.
    load(NUM_PIX, 1'b0);
    wait_start();
    repeat (5) tick();
    bnn_done = 1'b1;
    g = 0;
    while (bnn_addr_rd == '0 && g < 50) begin tick(); g++; end
    chk("read_seen", 64'(bnn_addr_rd != '0), 64'd1);
    tick();
    reset_pulse("reset_read_outs");

    // Clean image after resets: starts at address 0, all-equal scores pick index 0.
    for (int i = 0; i < NUM_OUT; i++) scores[i] = 8'd7;
    cq.push_back('{id: 4'd0, sc: 8'd7});
    load(NUM_PIX, 1'b1);
    finish_image(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bnn_host_ctrl.md
BNN_HOST_CTRL -- requirements
Module: bnn_host_ctrl

Interface
REQ-001 SHALL have parameter NUM_PIX, default 784, meaning pixels per image.
REQ-002 SHALL have parameter NUM_OUT, default 10, meaning class scores read back.
REQ-003 SHALL have parameter OUT_BASE, default 0, meaning read address of score 0.
REQ-004 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pix_valid  in  1  pixel stream valid.
REQ-007 SHALL have port pix_data  in  8  pixel value.
REQ-008 SHALL have port pix_ready  out  1  pixel accepted when pix_valid and pix_ready are both high.
REQ-009 SHALL have port bnn_enb_wr  out  1  activation memory write enable.
REQ-010 SHALL have port bnn_wr_data  out  8  activation write data.
REQ-011 SHALL have port bnn_addr_wr  out  11  activation write address.
REQ-012 SHALL have port bnn_addr_rd  out  11  activation read address.
REQ-013 SHALL have port bnn_start  out  1  inference start.
REQ-014 SHALL have port bnn_done  in  1  inference complete, level.
REQ-015 SHALL have port bnn_act_out  in  8  read data, unsigned, valid 1 cycle after bnn_addr_rd.
REQ-016 SHALL have port class_valid  out  1  result valid.
REQ-017 SHALL have port class_ready  in  1  result consumed when class_valid and class_ready are both high.
REQ-018 SHALL have port class_id  out  4  winning class index.
REQ-019 SHALL have port class_score  out  8  winning score.
REQ-020 SHALL have port busy  out  1  high in every state except LOAD with pixel count 0.

Function
REQ-021 SHALL implement states LOAD, START, WAIT, READ, RESULT; reset state LOAD.
REQ-022 LOAD: pix_ready SHALL be 1; the k-th accepted pixel (k from 0) SHALL produce bnn_enb_wr=1, bnn_addr_wr=k, bnn_wr_data=pix_data in the cycle after acceptance (registered, 1-cycle latency).
REQ-023 Cycles with no handshake SHALL produce bnn_enb_wr=0 the following cycle; addr/data hold last values.
REQ-024 The handshake accepting pixel NUM_PIX-1 SHALL move to START; pix_ready SHALL be 0 outside LOAD.
REQ-025 START: bnn_start SHALL be 1 for exactly 2 cycles, beginning the cycle after the final write, then move to WAIT.
REQ-026 WAIT: bnn_done SHALL be ignored during START; the first cycle in WAIT with bnn_done=1 SHALL move to READ.
REQ-027 READ: bnn_addr_rd SHALL step OUT_BASE, OUT_BASE+1, ... OUT_BASE+NUM_OUT-1, one per cycle; each bnn_act_out SHALL be sampled 1 cycle after its address.
REQ-028 Argmax SHALL use unsigned 8-bit compare, strictly-greater replaces; ties keep the lowest index; index 0 initialises the best.
REQ-029 READ SHALL last NUM_OUT+1 cycles, then move to RESULT with class_id/class_score registered.
REQ-030 RESULT: class_valid SHALL be 1 and class_id/class_score stable until class_ready=1; on that handshake move to LOAD with pixel count 0.
REQ-031 class_valid SHALL be 0 in all other states; class_ready outside RESULT SHALL be ignored.
REQ-032 Pixel counter SHALL be 11 bits, never wrap past NUM_PIX-1 within one image.
REQ-033 bnn_addr_rd SHALL be 0 outside READ.

Reset
REQ-034 rst_n=0 SHALL immediately force state LOAD, pixel count 0, and all outputs 0 except pix_ready=1 after release; applies mid-operation in any state.
REQ-035 First pixel accepted after reset release SHALL be written to address 0.

Verification
REQ-036 Stream 784 pixels back-to-back (value = addr mod 256) -> 784 writes, addr 0..783 in order, data matching, bnn_start high exactly 2 cycles after last write.
REQ-037 Stream with random pix_valid gaps -> write count 784, no duplicate/skipped addresses, bnn_enb_wr=0 on gap cycles.
REQ-038 bnn_done held 1 from before start; model drops it during START, raises 30 cycles later -> READ begins only after that rise; addr_rd 0..9.
REQ-039 Scores {3,200,7,200,0,0,0,0,0,255} -> class_id=9, class_score=255; scores {5,9,9,1,...} -> class_id=1, class_score=9.
REQ-040 class_ready held 0 for 20 cycles in RESULT -> class_valid and outputs stable; then 1 -> LOAD, pix_ready=1, busy=0.
REQ-041 rst_n pulsed low after 400 pixels and again in READ -> outputs zero immediately; next image loads from address 0 and completes normally.
